// File: rtl/gpio_bus_arbiter.sv
// Two-port arbiter in front of a GPIO register block: picks one requester,
// runs a single 4-cycle transaction (IDLE/ISSUE/RESP/DONE) and returns read data with an ack.
`timescale 1ns/1ps
module gpio_bus_arbiter #(
   parameter int unsigned DW          = 32,
   parameter int unsigned AW          = 2,
   parameter int unsigned PRIO0_FIXED = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] wd0,
   output logic          ack0,
   output logic [DW-1:0] rd0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] wd1,
   output logic          ack1,
   output logic [DW-1:0] rd1,
   output logic [AW-1:0] gpio_A,
   output logic          gpio_WE,
   output logic [DW-1:0] gpio_WD,
   input  logic [DW-1:0] gpio_RD,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic          grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] gpio_a_q, gpio_a_d;
   logic          gpio_we_q, gpio_we_d;
   logic [DW-1:0] gpio_wd_q, gpio_wd_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rd0_q, rd0_d;
   logic [DW-1:0] rd1_q, rd1_d;
   logic          pick;

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sel_q     <= 1'b0;
         last_q    <= 1'b1;
         grant_q   <= 1'b0;
         busy_q    <= 1'b0;
         gpio_a_q  <= '0;
         gpio_we_q <= 1'b0;
         gpio_wd_q <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rd0_q     <= '0;
         rd1_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         gpio_a_q  <= gpio_a_d;
         gpio_we_q <= gpio_we_d;
         gpio_wd_q <= gpio_wd_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
      end
   end

   // Next-state logic: arbitration in IDLE, command latch, read capture and ack.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      gpio_a_d  = gpio_a_q;
      gpio_we_d = 1'b0;
      gpio_wd_d = gpio_wd_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rd0_d     = rd0_q;
      rd1_d     = rd1_q;
      pick      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0 && req1) begin
               pick = (PRIO0_FIXED != 0) ? 1'b0 : ~last_q;
            end else begin
               pick = req1;
            end
            if (req0 || req1) begin
               sel_d     = pick;
               grant_d   = pick;
               gpio_a_d  = pick ? a1 : a0;
               gpio_wd_d = pick ? wd1 : wd0;
               gpio_we_d = pick ? we1 : we0;
               busy_d    = 1'b1;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (sel_q) begin
               rd1_d  = gpio_RD;
               ack1_d = 1'b1;
            end else begin
               rd0_d  = gpio_RD;
               ack0_d = 1'b1;
            end
            last_d  = sel_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign rd0     = rd0_q;
   assign rd1     = rd1_q;
   assign gpio_A  = gpio_a_q;
   assign gpio_WE = gpio_we_q;
   assign gpio_WD = gpio_wd_q;
   assign busy    = busy_q;
   assign grant   = grant_q;

endmodule
